// File: rtl/seq_mult4_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult4_ctrl_pkg
// Shared definitions for the 4x4 sequential shift-and-add multiplier
// sequencer: FSM state encoding, the last iteration index and a helper
// that gates the multiplicand with the current multiplier bit.
// ----------------------------------------------------------------------------
package seq_mult4_ctrl_pkg;

    // 2'd3 is never entered; the FSM treats it like IDLE so a corrupted
    // state register recovers to a sane condition.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    // Iteration counter value on the final add/shift step.
    localparam logic [1:0] ITER_LAST = 2'd3;

    // Partial-product addend: the multiplicand when the current multiplier
    // LSB is set, zero otherwise.
    function automatic logic [3:0] gate_multiplicand(input logic [3:0] m,
                                                     input logic       q0);
        logic [3:0] result;
        if (q0) begin
            result = m;
        end else begin
            result = 4'h0;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mult4_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_mult4_ctrl_if
// Start/Ready request handshake between a requesting unit and the
// multiplier sequencer.
//   Start   : request, accepted on a rising edge where Ready=1
//   A, B    : 4-bit multiplicand / multiplier, captured on the accepting edge
//   Ready   : sequencer idle
//   Busy    : iterations in progress
//   Done    : completion flag
//   Product : 8-bit registered result
// master = requesting unit, slave = sequencer.
// ----------------------------------------------------------------------------
interface seq_mult4_ctrl_if;

    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Ready;
    logic       Busy;
    logic       Done;
    logic [7:0] Product;

    modport master (
        output Start, A, B,
        input  Ready, Busy, Done, Product
    );

    modport slave (
        input  Start, A, B,
        output Ready, Busy, Done, Product
    );

endinterface

// File: rtl/seq_mult4_ctrl_adder.sv
// ----------------------------------------------------------------------------
// seq_mult4_ctrl_adder
// The shared 4-bit ripple-carry adder (Four_Bit_Adder datapath) that the
// sequencer time-shares across all multiply iterations.
//   a, b : 4-bit addends
//   cin  : carry-in (tied to 0 by the sequencer)
//   s    : 4-bit sum
//   c    : carry-out
// ----------------------------------------------------------------------------
module seq_mult4_ctrl_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c
);

    logic [4:0] carry_s;

    // Ripple chain of four full adders.
    always_comb begin
        carry_s    = 5'b0_0000;
        s          = 4'h0;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        c = carry_s[4];
    end

endmodule

// File: rtl/seq_mult4_ctrl.sv
// ----------------------------------------------------------------------------
// seq_mult4_ctrl
// Sequencer for a 4x4 unsigned shift-and-add multiply. One accepted Start
// loads the operands, then four RUN cycles each add the gated multiplicand
// into the upper half of the {Phi,Q} partial product and shift right by one.
// The final shift lands in Product and the FSM spends one cycle in DONE.
//   Clk  : system clock, rising edge
//   Rst  : asynchronous active-high reset
//   bus  : slave side of the Start/Ready handshake (see seq_mult4_ctrl_if)
// Parameter DONE_STICKY: 0 = Done pulses for one cycle; 1 = Done holds from
// completion until the edge that accepts the next Start.
// ----------------------------------------------------------------------------
module seq_mult4_ctrl
    import seq_mult4_ctrl_pkg::*;
#(
    parameter bit DONE_STICKY = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst,
    seq_mult4_ctrl_if.slave     bus
);

    state_t     state_r,   state_s;
    logic [3:0] m_r,       m_s;
    logic [3:0] q_r,       q_s;
    logic [3:0] phi_r,     phi_s;
    logic [1:0] cnt_r,     cnt_s;
    logic [7:0] product_r, product_s;
    logic       ready_r,   ready_s;
    logic       busy_r,    busy_s;
    logic       done_r,    done_s;

    logic [3:0] addend_s;
    logic [3:0] sum_s;
    logic       carry_s;

    assign addend_s = gate_multiplicand(m_r, q_r[0]);

    seq_mult4_ctrl_adder u_adder (
        .a   (phi_r),
        .b   (addend_s),
        .cin (1'b0),
        .s   (sum_s),
        .c   (carry_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_s   = state_r;
        m_s       = m_r;
        q_s       = q_r;
        phi_s     = phi_r;
        cnt_s     = cnt_r;
        product_s = product_r;

        case (state_r)
            ST_RUN: begin
                // Carry-out becomes the new MSB, so nothing is ever lost.
                {phi_s, q_s} = {carry_s, sum_s, q_r[3:1]};
                cnt_s        = cnt_r + 2'd1;
                if (cnt_r == ITER_LAST) begin
                    product_s = {carry_s, sum_s, q_r[3:1]};
                    state_s   = ST_DONE;
                end else begin
                    state_s   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                // ST_IDLE, and the unused encoding which behaves as IDLE.
                if (bus.Start) begin
                    state_s = ST_RUN;
                    m_s     = bus.A;
                    q_s     = bus.B;
                    phi_s   = 4'h0;
                    cnt_s   = 2'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        ready_s = (state_s == ST_IDLE);
        busy_s  = (state_s == ST_RUN);
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else if (DONE_STICKY && (state_s == ST_IDLE)) begin
            done_s = done_r;
        end else begin
            done_s = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            m_r       <= 4'h0;
            q_r       <= 4'h0;
            phi_r     <= 4'h0;
            cnt_r     <= 2'd0;
            product_r <= 8'h00;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            m_r       <= m_s;
            q_r       <= q_s;
            phi_r     <= phi_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign bus.Ready   = ready_r;
    assign bus.Busy    = busy_r;
    assign bus.Done    = done_r;
    assign bus.Product = product_r;

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_mult4_ctrl
// Directed bench for seq_mult4_ctrl: one pulse-Done instance and one
// sticky-Done instance sharing clock and reset. Inputs change and outputs
// are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_seq_mult4_ctrl;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    seq_mult4_ctrl_if bus0 ();
    seq_mult4_ctrl_if bus1 ();

    seq_mult4_ctrl #(.DONE_STICKY(1'b0)) u_pulse (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus0)
    );

    seq_mult4_ctrl #(.DONE_STICKY(1'b1)) u_sticky (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic nclk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Runs one operation on the pulse instance starting at a falling edge;
    // returns at the falling edge after the 4th RUN edge (Done cycle).
    task automatic op0(input logic [3:0] a, input logic [3:0] b, output int busy_n);
        busy_n      = 0;
        bus0.Start  = 1'b1;
        bus0.A      = a;
        bus0.B      = b;
        nclk(1);
        bus0.Start  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus0.Busy) busy_n++;
            nclk(1);
        end
    endtask

    task automatic test_reset();
        Rst        = 1'b1;
        bus0.Start = 1'b0; bus0.A = 4'h0; bus0.B = 4'h0;
        bus1.Start = 1'b0; bus1.A = 4'h0; bus1.B = 4'h0;
        #3;
        checks++;
        if ({bus0.Ready, bus0.Busy, bus0.Done, bus0.Product} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_pulse: got R/B/D/P %b%b%b %h expected 100 00",
                     bus0.Ready, bus0.Busy, bus0.Done, bus0.Product);
        end
        checks++;
        if ({bus1.Ready, bus1.Busy, bus1.Done, bus1.Product} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_sticky: got R/B/D/P %b%b%b %h expected 100 00",
                     bus1.Ready, bus1.Busy, bus1.Done, bus1.Product);
        end
        nclk(2);
        Rst = 1'b0;
        nclk(1);
    endtask

    task automatic test_basic();
        int bn;
        op0(4'hD, 4'hB, bn);
        checks++;
        if (bn !== 4) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bn);
        end
        checks++;
        if ({bus0.Ready, bus0.Busy, bus0.Done} !== 3'b001) begin
            errors++; $display("FAIL basic_done_flags: got R/B/D %b%b%b expected 001",
                               bus0.Ready, bus0.Busy, bus0.Done);
        end
        checks++;
        if (bus0.Product !== 8'h8F) begin
            errors++; $display("FAIL basic_product: got %h expected 8f", bus0.Product);
        end
        nclk(1);
        checks++;
        if ({bus0.Ready, bus0.Done, bus0.Product} !== {1'b1, 1'b0, 8'h8F}) begin
            errors++; $display("FAIL basic_return_idle: got R/D/P %b%b %h expected 10 8f",
                               bus0.Ready, bus0.Done, bus0.Product);
        end
    endtask

    task automatic test_carry();
        int bn;
        op0(4'hF, 4'hF, bn);
        checks++;
        if ({bus0.Done, bus0.Product} !== {1'b1, 8'hE1}) begin
            errors++; $display("FAIL carry_ff: got D/P %b %h expected 1 e1", bus0.Done, bus0.Product);
        end
        nclk(1);
        op0(4'h0, 4'h9, bn);
        checks++;
        if ({bus0.Done, bus0.Product} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL zero_operand: got D/P %b %h expected 1 00", bus0.Done, bus0.Product);
        end
        checks++;
        if (bn !== 4) begin
            errors++; $display("FAIL zero_busy_cycles: got %0d expected 4", bn);
        end
        nclk(1);
    endtask

    task automatic test_start_held();
        bus0.Start = 1'b1; bus0.A = 4'hD; bus0.B = 4'hB;
        nclk(1);
        bus0.A = 4'h1; bus0.B = 4'h1;
        nclk(4);
        checks++;
        if ({bus0.Done, bus0.Product} !== {1'b1, 8'h8F}) begin
            errors++; $display("FAIL held_first_result: got D/P %b %h expected 1 8f", bus0.Done, bus0.Product);
        end
        nclk(1);
        checks++;
        if ({bus0.Ready, bus0.Busy, bus0.Product} !== {1'b1, 1'b0, 8'h8F}) begin
            errors++; $display("FAIL held_idle_gap: got R/B/P %b%b %h expected 10 8f",
                               bus0.Ready, bus0.Busy, bus0.Product);
        end
        nclk(1);
        checks++;
        if ({bus0.Ready, bus0.Busy} !== 2'b01) begin
            errors++; $display("FAIL held_second_accept: got R/B %b%b expected 01", bus0.Ready, bus0.Busy);
        end
        bus0.Start = 1'b0;
        nclk(4);
        checks++;
        if ({bus0.Done, bus0.Product} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL held_second_result: got D/P %b %h expected 1 01", bus0.Done, bus0.Product);
        end
        nclk(1);
    endtask

    task automatic test_reset_mid();
        int  bn;
        bit  done_seen;
        bus0.Start = 1'b1; bus0.A = 4'hD; bus0.B = 4'hB;
        nclk(1);
        bus0.Start = 1'b0;
        nclk(1);
        #2 Rst = 1'b1;
        #1;
        checks++;
        if ({bus0.Ready, bus0.Busy, bus0.Done, bus0.Product} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL midrun_reset: got R/B/D/P %b%b%b %h expected 100 00",
                               bus0.Ready, bus0.Busy, bus0.Done, bus0.Product);
        end
        #1 Rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (bus0.Done) done_seen = 1'b1;
        end
        checks++;
        if ({done_seen, bus0.Ready} !== 2'b01) begin
            errors++; $display("FAIL midrun_no_done: got done_seen/R %b%b expected 01", done_seen, bus0.Ready);
        end
        op0(4'h2, 4'h3, bn);
        checks++;
        if ({bus0.Done, bus0.Product} !== {1'b1, 8'h06}) begin
            errors++; $display("FAIL midrun_restart: got D/P %b %h expected 1 06", bus0.Done, bus0.Product);
        end
        nclk(1);
    endtask

    task automatic test_sticky();
        bus1.Start = 1'b1; bus1.A = 4'h5; bus1.B = 4'h6;
        nclk(1);
        bus1.Start = 1'b0;
        nclk(4);
        checks++;
        if ({bus1.Done, bus1.Product} !== {1'b1, 8'h1E}) begin
            errors++; $display("FAIL sticky_done: got D/P %b %h expected 1 1e", bus1.Done, bus1.Product);
        end
        nclk(4);
        checks++;
        if ({bus1.Ready, bus1.Done, bus1.Product} !== {1'b1, 1'b1, 8'h1E}) begin
            errors++; $display("FAIL sticky_hold: got R/D/P %b%b %h expected 11 1e",
                               bus1.Ready, bus1.Done, bus1.Product);
        end
        bus1.Start = 1'b1; bus1.A = 4'h3; bus1.B = 4'h3;
        nclk(1);
        checks++;
        if ({bus1.Busy, bus1.Done, bus1.Product} !== {1'b1, 1'b0, 8'h1E}) begin
            errors++; $display("FAIL sticky_clear: got B/D/P %b%b %h expected 10 1e",
                               bus1.Busy, bus1.Done, bus1.Product);
        end
        bus1.Start = 1'b0;
        nclk(4);
        nclk(2);
        checks++;
        if ({bus1.Ready, bus1.Done, bus1.Product} !== {1'b1, 1'b1, 8'h09}) begin
            errors++; $display("FAIL sticky_second: got R/D/P %b%b %h expected 11 09",
                               bus1.Ready, bus1.Done, bus1.Product);
        end
    endtask

    task automatic test_back_to_back();
        int         done_cnt;
        logic [7:0] exp;
        done_cnt = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp        = 8'(a * b);
                bus0.Start = 1'b1;
                bus0.A     = 4'(a);
                bus0.B     = 4'(b);
                nclk(1);
                bus0.Start = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (bus0.Done) done_cnt++;
                    nclk(1);
                end
                if (bus0.Done) done_cnt++;
                checks++;
                if (bus0.Product !== exp) begin
                    errors++; $display("FAIL sweep_product a=%0d b=%0d: got %h expected %h",
                                       a, b, bus0.Product, exp);
                end
                nclk(1);
            end
        end
        checks++;
        if (done_cnt !== 256) begin
            errors++; $display("FAIL sweep_done_count: got %0d expected 256", done_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_reset_mid();
        test_sticky();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
